mul8x8_seq_sched: RTL and testbench

- Sequential 8x8 unsigned multiplier that time-shares one 4x4 multiplier core across the four nibble sub-products: LL, HL, LH, HH.
- Accumulates the shifted sub-products into a 16-bit result.
- Valid/ready handshake on both input and output.
- Used where area matters more than throughput. It is the sequenced counterpart of the fully parallel recursive 8x8 multipliers.

---
 rtl/mul_seq_pkg.sv | 46 ++++
 rtl/mul8x8_seq_sched_core.sv | 19 +
 rtl/mul8x8_seq_sched.sv | 139 +++++++++++++
 tb/tb_mul8x8_seq_sched.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mul_seq_pkg.sv
// Shared types and helpers for the sequenced 8x8 multiplier.
// Quadrant tables map a 2-bit index to nibble operands and shift.
package mul_seq_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    typedef logic [1:0] quad_t;

    // Element q is the left shift applied to quadrant q's product.
    localparam logic [3:0][3:0] SHIFT_TAB = {4'd8, 4'd4, 4'd4, 4'd0};

    // Returns {x, y}: the two nibbles fed to the core for quadrant q.
    function automatic logic [7:0] quad_nibbles(
        input logic [7:0] a,
        input logic [7:0] b,
        input quad_t      q
    );
        logic [7:0] r;
        unique case (q)
            2'd0: r = {a[3:0], b[3:0]};
            2'd1: r = {a[7:4], b[3:0]};
            2'd2: r = {b[7:4], a[3:0]};
            2'd3: r = {a[7:4], b[7:4]};
        endcase
        return r;
    endfunction

    // A quadrant stays pending unless skipping is on and a nibble is zero.
    function automatic logic [3:0] pend_mask(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic       skip
    );
        logic [3:0] m;
        m[0] = !skip || (a[3:0] != 4'd0 && b[3:0] != 4'd0);
        m[1] = !skip || (a[7:4] != 4'd0 && b[3:0] != 4'd0);
        m[2] = !skip || (a[3:0] != 4'd0 && b[7:4] != 4'd0);
        m[3] = !skip || (a[7:4] != 4'd0 && b[7:4] != 4'd0);
        return m;
    endfunction

endpackage

// File: rtl/mul8x8_seq_sched_core.sv
// Exact combinational 4x4 unsigned array multiplier.
// Shared by all four quadrants of the sequenced 8x8 multiplier.
module mul4x4_core (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P
);

    // Sum of the shifted partial-product rows.
    always_comb begin
        P = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (B[i]) begin
                P = P + ({4'd0, A} << i);
            end
        end
    end

endmodule

// File: rtl/mul8x8_seq_sched.sv
// Sequenced 8x8 unsigned multiplier built on one shared 4x4 core.
// One nibble quadrant is accumulated per cycle, zero quadrants optional.
module mul8x8_seq_sched
    import mul_seq_pkg::*;
#(
    parameter bit SKIP_ZERO = 1'b1,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       A,
    input  logic [7:0]       B,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      P,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);

    state_t      state_q;
    state_t      state_d;
    logic [7:0]  a_q;
    logic [7:0]  b_q;
    logic [15:0] acc_q;
    logic [3:0]  mask_q;

    quad_t       sel;
    logic [3:0]  core_a;
    logic [3:0]  core_b;
    logic [7:0]  core_p;
    logic [15:0] term;
    logic [15:0] acc_sum;
    logic [3:0]  mask_clr;

    mul4x4_core u_core (
        .A (core_a),
        .B (core_b),
        .P (core_p)
    );

    // Pick the lowest pending quadrant and form its shifted contribution.
    always_comb begin
        sel = 2'd3;
        if (mask_q[0]) begin
            sel = 2'd0;
        end else if (mask_q[1]) begin
            sel = 2'd1;
        end else if (mask_q[2]) begin
            sel = 2'd2;
        end
        {core_a, core_b} = quad_nibbles(a_q, b_q, sel);
        term     = {8'd0, core_p} << SHIFT_TAB[sel];
        acc_sum  = acc_q + term;
        mask_clr = mask_q & ~(4'b0001 << sel);
    end

    // Next-state logic and state-derived handshake outputs.
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        busy     = 1'b1;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (mask_clr == 4'd0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Operand latch, accumulator, result and completion counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q       <= 8'd0;
            b_q       <= 8'd0;
            acc_q     <= 16'd0;
            mask_q    <= 4'd0;
            P         <= 16'd0;
            out_valid <= 1'b0;
            op_count  <= '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_q    <= A;
                        b_q    <= B;
                        acc_q  <= 16'd0;
                        mask_q <= pend_mask(A, B, SKIP_ZERO);
                    end
                end
                CALC: begin
                    if (mask_q != 4'd0) begin
                        acc_q <= acc_sum;
                    end
                    mask_q <= mask_clr;
                    if (mask_clr == 4'd0) begin
                        P         <= (mask_q != 4'd0) ? acc_sum : acc_q;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        op_count  <= op_count + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul8x8_seq_sched.sv
// Randomised bench for mul8x8_seq_sched against a cycle-level model.
// Instance 0: no skipping, 16-bit counter. Instance 1: skipping, 4-bit.
module tb_mul8x8_seq_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    logic [1:0]       in_valid;
    logic [1:0]       in_ready;
    logic [1:0]       out_valid;
    logic [1:0]       out_ready;
    logic [1:0]       busy;
    logic [1:0][7:0]  a_in;
    logic [1:0][7:0]  b_in;
    logic [1:0][15:0] p_out;
    logic [15:0]      cnt0;
    logic [3:0]       cnt1;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    mul8x8_seq_sched #(.SKIP_ZERO(1'b0), .CNT_W(16)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .A         (a_in[0]),
        .B         (b_in[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .P         (p_out[0]),
        .busy      (busy[0]),
        .op_count  (cnt0)
    );

    mul8x8_seq_sched #(.SKIP_ZERO(1'b1), .CNT_W(4)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .A         (a_in[1]),
        .B         (b_in[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .P         (p_out[1]),
        .busy      (busy[1]),
        .op_count  (cnt1)
    );

    // Behavioural model state per instance.
    bit          m_idle [2] = '{1'b1, 1'b1};
    int          m_wait [2] = '{0, 0};
    bit          m_ov   [2] = '{1'b0, 1'b0};
    logic [15:0] m_exp  [2] = '{16'd0, 16'd0};
    logic [15:0] m_p    [2] = '{16'd0, 16'd0};
    int          m_cnt  [2] = '{0, 0};
    int          cw     [2] = '{16, 4};
    bit          skip   [2] = '{1'b0, 1'b1};

    task automatic check(input string nm, input int inst,
                         input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h t=%0t",
                     nm, inst, got, exp, $time);
        end
    endtask

    function automatic int lat_of(input int i, input logic [7:0] a,
                                  input logic [7:0] b);
        int n;
        if (!skip[i]) return 4;
        n = 0;
        if (a[3:0] != 0 && b[3:0] != 0) n++;
        if (a[7:4] != 0 && b[3:0] != 0) n++;
        if (a[3:0] != 0 && b[7:4] != 0) n++;
        if (a[7:4] != 0 && b[7:4] != 0) n++;
        return (n < 1) ? 1 : n;
    endfunction

    // Model: accept in idle, count down latency, hold until taken.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_idle[i] = 1'b1;
                m_wait[i] = 0;
                m_ov[i]   = 1'b0;
                m_p[i]    = 16'd0;
                m_cnt[i]  = 0;
            end else if (m_idle[i]) begin
                if (in_valid[i]) begin
                    m_exp[i]  = 16'(a_in[i]) * 16'(b_in[i]);
                    m_wait[i] = lat_of(i, a_in[i], b_in[i]);
                    m_idle[i] = 1'b0;
                end
            end else if (m_wait[i] > 0) begin
                m_wait[i]--;
                if (m_wait[i] == 0) begin
                    m_ov[i] = 1'b1;
                    m_p[i]  = m_exp[i];
                end
            end else if (out_ready[i]) begin
                m_ov[i]   = 1'b0;
                m_cnt[i]  = (m_cnt[i] + 1) % (1 << cw[i]);
                m_idle[i] = 1'b1;
            end
        end
    end

    // Compare every DUT output against the model each cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("in_ready", i, in_ready[i], m_idle[i]);
                check("busy", i, busy[i], !m_idle[i]);
                check("out_valid", i, out_valid[i], m_ov[i]);
                check("P", i, p_out[i], m_p[i]);
                check("op_count", i,
                      (i == 0) ? 32'(cnt0) : 32'(cnt1), m_cnt[i]);
            end
        end
    end

    task automatic run_op(input int i, input logic [7:0] a,
                          input logic [7:0] b, input int hold,
                          input int exp_lat, input logic [15:0] exp_p,
                          input bit lit);
        int n;
        int lat;
        a_in[i]     = a;
        b_in[i]     = b;
        in_valid[i] = 1'b1;
        n = 0;
        while (!in_ready[i] && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 50) check("accept_timeout", i, 1, 0);
        @(posedge clk);
        #1;
        in_valid[i] = 1'b0;
        a_in[i]     = 8'($urandom);
        b_in[i]     = 8'($urandom);
        lat = 0;
        while (!out_valid[i] && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lit) begin
            check("latency", i, lat, exp_lat);
            check("product", i, p_out[i], exp_p);
        end else if (lat >= 20) begin
            check("done_timeout", i, 1, 0);
        end
        for (int k = 0; k < hold; k++) begin
            in_valid[i] = k[0];
            @(posedge clk);
            #1;
            if (lit) begin
                check("held_p", i, p_out[i], exp_p);
                check("held_in_ready", i, in_ready[i], 0);
            end
        end
        in_valid[i]  = 1'b0;
        out_ready[i] = 1'b1;
        @(posedge clk);
        #1;
        out_ready[i] = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        in_valid  = '0;
        out_ready = '0;
        a_in      = '0;
        b_in      = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;

        for (int i = 0; i < 2; i++) begin
            check("rst_in_ready", i, in_ready[i], 1);
            check("rst_out_valid", i, out_valid[i], 0);
            check("rst_P", i, p_out[i], 0);
            check("rst_busy", i, busy[i], 0);
        end
        check("rst_cnt", 0, cnt0, 0);
        check("rst_cnt", 1, cnt1, 0);

        run_op(0, 8'hFF, 8'hFF, 0, 4, 16'hFE01, 1'b1);
        check("cnt_after_1", 0, cnt0, 1);

        run_op(1, 8'h12, 8'h34, 0, 4, 16'h03A8, 1'b1);
        run_op(1, 8'h0F, 8'h0F, 0, 1, 16'h00E1, 1'b1);
        run_op(1, 8'h00, 8'hC7, 0, 1, 16'h0000, 1'b1);
        run_op(1, 8'hF0, 8'h0F, 0, 1, 16'h0E10, 1'b1);
        check("cnt_after_4", 1, cnt1, 4);

        run_op(1, 8'hAB, 8'hCD, 5, 4, 16'h88EF, 1'b1);
        check("cnt_after_bp", 1, cnt1, 5);

        a_in[1]     = 8'h99;
        b_in[1]     = 8'h77;
        in_valid[1] = 1'b1;
        @(posedge clk);
        #1;
        in_valid[1] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("mid_rst_out_valid", 1, out_valid[1], 0);
        check("mid_rst_P", 1, p_out[1], 0);
        check("mid_rst_cnt", 1, cnt1, 0);
        check("mid_rst_in_ready", 1, in_ready[1], 1);
        run_op(1, 8'h03, 8'h05, 0, 1, 16'h000F, 1'b1);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int k = 0; k < 17; k++) begin
            run_op(1, 8'($urandom), 8'($urandom), 0, 0, 16'd0, 1'b0);
        end
        check("cnt_wrap", 1, cnt1, 1);

        for (int k = 0; k < 1000; k++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            if ($urandom_range(3) == 0) ra = ra & 8'hF0;
            if ($urandom_range(3) == 0) ra = ra & 8'h0F;
            if ($urandom_range(3) == 0) rb = rb & 8'hF0;
            if ($urandom_range(3) == 0) rb = rb & 8'h0F;
            run_op(k % 2, ra, rb, $urandom_range(0, 3), 0, 16'd0, 1'b0);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
